// File: rtl/ap_txn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ap_txn_pkg
//  Brief    : Shared types for the ap_ctrl_chain transaction tracker:
//             start-queue entry, completed-transaction record and the
//             start-capture FSM encoding.
//             Optional feature macro: AP_TXN_TRACKER_STALL_CNT_EN adds a
//             stall field to the record.
//  Revision : 1.0  initial release
// ============================================================================
package ap_txn_pkg;

    // Record field widths. The tracker's CNT_W / ID_W parameters must match
    // these because the record layout is fixed here.
    localparam int AP_CNT_W = 32;
    localparam int AP_ID_W  = 16;

    // Start-capture FSM states
    typedef enum logic [0:0] {
        ST_ARMED      = 1'b0,
        ST_WAIT_READY = 1'b1
    } ap_txn_state_e;

    // One outstanding transaction: captured when ap_start is accepted
    typedef struct packed {
        logic [AP_ID_W-1:0]  id;
        logic [AP_CNT_W-1:0] start;
        logic [AP_CNT_W-1:0] interval;
    } ap_txn_start_t;

    // One completed transaction handed to the monitor
    typedef struct packed {
        logic [AP_ID_W-1:0]  id;
        logic [AP_CNT_W-1:0] start;
        logic [AP_CNT_W-1:0] latency;
        logic [AP_CNT_W-1:0] interval;
`ifdef AP_TXN_TRACKER_STALL_CNT_EN
        logic [AP_CNT_W-1:0] stall;
`endif
    } ap_txn_rec_t;

    // Modulo-2^CNT_W difference used for latency and interval
    function automatic logic [AP_CNT_W-1:0] cnt_diff(
        input logic [AP_CNT_W-1:0] a,
        input logic [AP_CNT_W-1:0] b
    );
        return a - b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ap_txn_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : ap_txn_tracker_if
//  Brief    : ap_ctrl_chain handshake observed by the tracker plus the
//             valid/ready record output and status flags.
//             master = HLS instance / consumer side, slave = tracker.
//             Optional feature macro: AP_TXN_TRACKER_STALL_CNT_EN adds
//             rec_stall.
//  Revision : 1.0  initial release
// ============================================================================
interface ap_txn_tracker_if
    import ap_txn_pkg::*;
#(
    parameter int CNT_W = AP_CNT_W,
    parameter int ID_W  = AP_ID_W
);
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             finish;
    logic             rec_valid;
    logic             rec_ready;
    logic [ID_W-1:0]  rec_id;
    logic [CNT_W-1:0] rec_start;
    logic [CNT_W-1:0] rec_latency;
    logic [CNT_W-1:0] rec_interval;
`ifdef AP_TXN_TRACKER_STALL_CNT_EN
    logic [CNT_W-1:0] rec_stall;
`endif
    logic [ID_W-1:0]  txn_count;
    logic             overflow;
    logic             proto_err;
    logic             drained;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
        input  rec_valid, rec_id, rec_start, rec_latency, rec_interval,
`ifdef AP_TXN_TRACKER_STALL_CNT_EN
        input  rec_stall,
`endif
        input  txn_count, overflow, proto_err, drained
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
        output rec_valid, rec_id, rec_start, rec_latency, rec_interval,
`ifdef AP_TXN_TRACKER_STALL_CNT_EN
        output rec_stall,
`endif
        output txn_count, overflow, proto_err, drained
    );
endinterface
`default_nettype wire

// File: rtl/ap_txn_rec_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ap_txn_rec_fifo
//  Brief    : Generic first-word-fall-through synchronous FIFO. data_o shows
//             the head entry whenever empty_o is low. A push into a full
//             FIFO is accepted only if a pop happens in the same cycle.
//             DEPTH must be a power of two, at least 2.
//  Revision : 1.0  initial release
// ============================================================================
module ap_txn_rec_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic push_i,
    input  wire T     data_i,
    input  wire logic pop_i,
    output T          data_o,
    output logic      empty_o,
    output logic      accept_o
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o  = (count_q == '0);
    assign pop_ok   = pop_i & ~empty_o;
    assign push_ok  = push_i & ((count_q != FULL_CNT) | pop_ok);
    assign accept_o = push_ok;
    assign data_o   = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ap_txn_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : ap_txn_tracker
//  Brief    : Watches one HLS ap_ctrl_chain instance, timestamps each start,
//             matches it with the next done and emits {id, start, latency,
//             interval} records through a FWFT valid/ready FIFO.
//             Optional feature macro: AP_TXN_TRACKER_STALL_CNT_EN adds
//             rec_stall (done-held-without-continue cycle count).
//  Revision : 1.0  initial release
// ============================================================================
module ap_txn_tracker
    import ap_txn_pkg::*;
#(
    parameter int CNT_W = AP_CNT_W,   // must equal AP_CNT_W
    parameter int ID_W  = AP_ID_W,    // must equal AP_ID_W
    parameter int OUTST = 4,
    parameter int DEPTH = 8
) (
    input  wire logic       ap_clk,
    input  wire logic       ap_rst_n,
    ap_txn_tracker_if.slave bus
);
    ap_txn_state_e    state_q, state_d;
    logic [CNT_W-1:0] now_q;
    logic [CNT_W-1:0] prev_start_q;
    logic             have_prev_q;
    logic [ID_W-1:0]  next_id_q;
    logic [ID_W-1:0]  txn_count_q;
    logic             overflow_q;
    logic             proto_err_q;
`ifdef AP_TXN_TRACKER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;
`endif

    logic          start_evt;
    logic          done_evt;
    ap_txn_start_t sq_din, sq_head;
    logic          sq_empty, sq_accept, sq_pop;
    ap_txn_rec_t   rf_din, rf_head;
    logic          rf_empty, rf_accept, rf_push, rf_pop;

    assign start_evt = (state_q == ST_ARMED) & bus.ap_start & ~bus.finish;
    assign done_evt  = bus.ap_done & bus.ap_continue;
    assign sq_pop    = done_evt & ~sq_empty;
    assign rf_push   = sq_pop;
    assign rf_pop    = ~rf_empty & bus.rec_ready;

    // Start-queue entry: id, timestamp and distance from the previous start
    always_comb begin
        sq_din          = '0;
        sq_din.id       = next_id_q;
        sq_din.start    = now_q;
        sq_din.interval = have_prev_q ? cnt_diff(now_q, prev_start_q) : '0;
    end

    // Completed record formed from the oldest outstanding start
    always_comb begin
        rf_din          = '0;
        rf_din.id       = sq_head.id;
        rf_din.start    = sq_head.start;
        rf_din.latency  = cnt_diff(now_q, sq_head.start);
        rf_din.interval = sq_head.interval;
`ifdef AP_TXN_TRACKER_STALL_CNT_EN
        rf_din.stall    = stall_q;
`endif
    end

    ap_txn_rec_fifo #(
        .T     (ap_txn_start_t),
        .DEPTH (OUTST)
    ) u_start_q (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .push_i   (start_evt),
        .data_i   (sq_din),
        .pop_i    (sq_pop),
        .data_o   (sq_head),
        .empty_o  (sq_empty),
        .accept_o (sq_accept)
    );

    ap_txn_rec_fifo #(
        .T     (ap_txn_rec_t),
        .DEPTH (DEPTH)
    ) u_rec_fifo (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .push_i   (rf_push),
        .data_i   (rf_din),
        .pop_i    (rf_pop),
        .data_o   (rf_head),
        .empty_o  (rf_empty),
        .accept_o (rf_accept)
    );

    // Start-capture FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // A start without ready waits for ready before another start can count
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARMED: begin
                if (start_evt && !bus.ap_ready) begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (bus.ap_ready) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    // Cycle counter, id/count tracking and sticky error flags
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            now_q        <= '0;
            prev_start_q <= '0;
            have_prev_q  <= 1'b0;
            next_id_q    <= '0;
            txn_count_q  <= '0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            now_q <= now_q + 1'b1;
            if (start_evt) begin
                // dropped starts still consume an id and advance the interval base
                prev_start_q <= now_q;
                have_prev_q  <= 1'b1;
                next_id_q    <= next_id_q + 1'b1;
            end
            if (rf_push) begin
                txn_count_q <= txn_count_q + 1'b1;
            end
            if ((start_evt && !sq_accept) || (rf_push && !rf_accept)) begin
                overflow_q <= 1'b1;
            end
            if (done_evt && sq_empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

`ifdef AP_TXN_TRACKER_STALL_CNT_EN
    // Cycles spent with done held back by ap_continue since the last done event
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_q <= '0;
        end else if (done_evt) begin
            stall_q <= '0;
        end else if (bus.ap_done) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.rec_stall = rf_empty ? '0 : rf_head.stall;
`endif

    // Record outputs read as zero while no record is pending
    assign bus.rec_valid    = ~rf_empty;
    assign bus.rec_id       = rf_empty ? '0 : rf_head.id;
    assign bus.rec_start    = rf_empty ? '0 : rf_head.start;
    assign bus.rec_latency  = rf_empty ? '0 : rf_head.latency;
    assign bus.rec_interval = rf_empty ? '0 : rf_head.interval;
    assign bus.txn_count    = txn_count_q;
    assign bus.overflow     = overflow_q;
    assign bus.proto_err    = proto_err_q;
    assign bus.drained      = bus.finish & sq_empty & rf_empty;
endmodule
`default_nettype wire

// File: tb/tb_ap_txn_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ap_txn_tracker
//  Brief    : Self-checking bench for ap_txn_tracker: table-driven single
//             transaction, directed corner sequences and randomized traffic
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ap_txn_tracker;
    localparam int OUTST = 4;
    localparam int DEPTH = 8;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    ap_txn_tracker_if #(.CNT_W(32), .ID_W(16)) bus ();

    ap_txn_tracker #(
        .CNT_W (32),
        .ID_W  (16),
        .OUTST (OUTST),
        .DEPTH (DEPTH)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] id;
        logic [31:0] st;
        logic [31:0] iv;
    } m_start_t;
    typedef struct {
        logic [15:0] id;
        logic [31:0] st;
        logic [31:0] lat;
        logic [31:0] iv;
    } m_rec_t;

    m_start_t    m_sq[$];
    m_rec_t      m_rq[$];
    logic [31:0] m_now, m_prev;
    logic [15:0] m_next_id, m_cnt;
    bit          m_first, m_armed, m_ovf, m_perr, m_fin;

    task automatic m_reset();
        m_sq.delete();
        m_rq.delete();
        m_now = 0; m_prev = 0; m_next_id = 0; m_cnt = 0;
        m_first = 1; m_armed = 1; m_ovf = 0; m_perr = 0; m_fin = 0;
    endtask

    // One clock cycle of the tracker's behaviour given the applied inputs
    task automatic m_step(input bit s, input bit r, input bit d, input bit c,
                          input bit f, input bit rr);
        bit st_ev, dn_ev;
        m_start_t h, e;
        m_rec_t   rc;
        st_ev = m_armed && s && !f;
        dn_ev = d && c;
        m_fin = f;
        if (m_rq.size() > 0 && rr) void'(m_rq.pop_front());
        if (dn_ev) begin
            if (m_sq.size() == 0) m_perr = 1;
            else begin
                h = m_sq.pop_front();
                rc.id = h.id; rc.st = h.st; rc.lat = m_now - h.st; rc.iv = h.iv;
                m_cnt++;
                if (m_rq.size() < DEPTH) m_rq.push_back(rc);
                else m_ovf = 1;
            end
        end
        if (st_ev) begin
            e.id = m_next_id;
            e.st = m_now;
            e.iv = m_first ? 32'd0 : m_now - m_prev;
            m_prev = m_now;
            m_first = 0;
            if (m_sq.size() < OUTST) m_sq.push_back(e);
            else m_ovf = 1;
            m_next_id++;
        end
        if (m_armed) begin
            if (st_ev && !r) m_armed = 0;
        end else if (r) begin
            m_armed = 1;
        end
        m_now++;
    endtask

    // Drive inputs (at a negedge), advance model, move to the next negedge
    task automatic apply(input bit s, input bit r, input bit d, input bit c,
                         input bit f, input bit rr);
        bus.ap_start = s; bus.ap_ready = r; bus.ap_done = d;
        bus.ap_continue = c; bus.finish = f; bus.rec_ready = rr;
        m_step(s, r, d, c, f, rr);
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic check_model();
        bit ev;
        ev = (m_rq.size() > 0);
        chk("rec_valid", bus.rec_valid, ev);
        chk("rec_id",       bus.rec_id,       ev ? m_rq[0].id  : 16'd0);
        chk("rec_start",    bus.rec_start,    ev ? m_rq[0].st  : 32'd0);
        chk("rec_latency",  bus.rec_latency,  ev ? m_rq[0].lat : 32'd0);
        chk("rec_interval", bus.rec_interval, ev ? m_rq[0].iv  : 32'd0);
        chk("txn_count", bus.txn_count, m_cnt);
        chk("overflow",  bus.overflow,  m_ovf);
        chk("proto_err", bus.proto_err, m_perr);
        chk("drained",   bus.drained,   m_fin && m_sq.size() == 0 && m_rq.size() == 0);
    endtask

    task automatic cyc(input bit s, input bit r, input bit d, input bit c,
                       input bit f, input bit rr);
        apply(s, r, d, c, f, rr);
        check_model();
    endtask

    // Assert reset at a negedge, check outputs clear at once, release later
    task automatic do_reset();
        @(negedge ap_clk);
        bus.ap_start = 0; bus.ap_ready = 0; bus.ap_done = 0;
        bus.ap_continue = 0; bus.finish = 0; bus.rec_ready = 0;
        ap_rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_valid",    bus.rec_valid, 0);
        chk("rst_id",       bus.rec_id, 0);
        chk("rst_start",    bus.rec_start, 0);
        chk("rst_latency",  bus.rec_latency, 0);
        chk("rst_interval", bus.rec_interval, 0);
        chk("rst_count",    bus.txn_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_proto",    bus.proto_err, 0);
        chk("rst_drained",  bus.drained, 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit          s, r, d, c, rr;
        bit          ev;
        logic [15:0] eid;
        logic [31:0] est, elat, eiv;
        logic [15:0] ecnt;
    } vec_t;
    vec_t vt[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // single transaction: start@5 with ready, done@12, pop @14
        for (int i = 0; i < 15; i++) vt[i] = '{default: 0};
        vt[5].s = 1; vt[5].r = 1;
        vt[12].d = 1; vt[12].c = 1;
        for (int i = 12; i <= 13; i++) begin
            vt[i].ev = 1; vt[i].eid = 0; vt[i].est = 5; vt[i].elat = 7; vt[i].eiv = 0;
        end
        for (int i = 12; i <= 14; i++) vt[i].ecnt = 1;
        vt[14].rr = 1;

        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply(vt[i].s, vt[i].r, vt[i].d, vt[i].c, 1'b0, vt[i].rr);
            chk("tbl_valid",    bus.rec_valid,    vt[i].ev);
            chk("tbl_id",       bus.rec_id,       vt[i].eid);
            chk("tbl_start",    bus.rec_start,    vt[i].est);
            chk("tbl_latency",  bus.rec_latency,  vt[i].elat);
            chk("tbl_interval", bus.rec_interval, vt[i].eiv);
            chk("tbl_count",    bus.txn_count,    vt[i].ecnt);
            chk("tbl_proto",    bus.proto_err,    1'b0);
        end

        // pipelined: starts 10/13/16, dones 20/23/26
        do_reset();
        for (int c = 0; c < 30; c++) begin
            bit s, d;
            s = (c == 10) || (c == 13) || (c == 16);
            d = (c == 20) || (c == 23) || (c == 26);
            cyc(s, s, d, d, 1'b0, 1'b1);
            if (d) begin
                chk("pipe_latency", bus.rec_latency, 10);
                chk("pipe_interval", bus.rec_interval, (c == 20) ? 0 : 3);
            end
        end

        // backpressure: 9 completions into an 8-deep FIFO
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, 0, 0, 0, 0);
            cyc(0, 0, 1, 1, 0, 0);
        end
        chk("bp_count", bus.txn_count, 9);
        chk("bp_overflow", bus.overflow, 1);
        for (int k = 0; k < 8; k++) begin
            chk("bp_order", bus.rec_id, k);
            cyc(0, 0, 0, 0, 0, 1);
        end
        chk("bp_empty", bus.rec_valid, 0);

        // stray done at cycle 4
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cyc(0, 0, c == 4, c == 4, 0, 1);
            chk("stray_proto", bus.proto_err, c >= 4);
            chk("stray_valid", bus.rec_valid, 0);
        end

        // mid-run reset with 2 outstanding and 1 pending record
        do_reset();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("mid_pending", bus.rec_valid, 1);
        do_reset();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        chk("mid_id0", bus.rec_id, 0);
        chk("mid_valid", bus.rec_valid, 1);

        // finish with one outstanding start and ap_start held
        do_reset();
        for (int c = 0; c < 37; c++) begin
            bit f;
            f = (c >= 30);
            cyc((c == 20) || f, c == 20, c == 35, c == 35, f, c == 36);
            if (c == 35) begin
                chk("fin_valid", bus.rec_valid, 1);
                chk("fin_id", bus.rec_id, 0);
                chk("fin_latency", bus.rec_latency, 15);
                chk("fin_drained_pend", bus.drained, 0);
            end
        end
        chk("fin_drained", bus.drained, 1);
        chk("fin_count", bus.txn_count, 1);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit s, r, d, cn, f, rr;
            s  = ($urandom_range(2, 0) == 0);
            r  = ($urandom_range(1, 0) == 0);
            d  = (m_sq.size() > 0) ? ($urandom_range(2, 0) == 0)
                                   : ($urandom_range(39, 0) == 0);
            cn = ($urandom_range(3, 0) != 0);
            f  = (c >= 2800);
            rr = ((c / 200) % 2 == 1) ? 1'b0 : ($urandom_range(2, 0) != 0);
            cyc(s, r, d, cn, f, rr);
        end
        for (int c = 0; c < 20; c++) cyc(0, 0, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ap_txn_tracker.md
# ap_txn_tracker

Synthesizable transaction tracker that sits directly upstream of the per-module status monitor and CSV dumper. It watches the ap_ctrl_chain handshake of one HLS top-level instance (ap_start/ap_ready/ap_done/ap_continue) and timestamps each transaction. It emits one record per completed transaction (id, start cycle, latency, interval) through a valid/ready FIFO that the monitor drains.

## Interface
- CNT_W, 32: cycle counter, timestamp, latency and interval width
- ID_W, 16: transaction id width
- OUTST, 4: max outstanding transactions (started, not done); power of two
- DEPTH, 8: record FIFO depth; power of two

- ap_clk  in  1  sole clock, rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- ap_start  in  1  DUT start
- ap_ready  in  1  DUT ready (input accepted)
- ap_done  in  1  DUT done
- ap_continue  in  1  downstream continue; tie 1 for ap_ctrl_hs
- finish  in  1  end of simulation/test; stops new start capture
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_id  out  ID_W  transaction id
- rec_start  out  CNT_W  start timestamp
- rec_latency  out  CNT_W  done cycle minus start cycle
- rec_interval  out  CNT_W  start minus previous start; 0 for first
- txn_count  out  ID_W  completed transactions
- overflow  out  1  sticky: record or start queue dropped an event
- proto_err  out  1  sticky: done with no outstanding start
- drained  out  1  finish seen, start queue and FIFO empty

## Operation
- Free-running cycle counter `now` increments every cycle from 0 after reset; wraps modulo 2^CNT_W. All differences are computed modulo 2^CNT_W.
- Start FSM: ARMED / WAIT_READY.
  - ARMED & ap_start & !finish -> start event. Push {next_id, now} into the start queue, compute interval, then next_id++.
  - If ap_ready is also high in that cycle, stay ARMED; otherwise go to WAIT_READY.
  - WAIT_READY & ap_ready -> ARMED. Re-arming takes effect the next cycle.
- Done event: ap_done & ap_continue.
  - Pop the start queue head and form the record with latency = now - head.start.
  - Push the record to the FIFO and increment txn_count. txn_count wraps.
- Done event with empty start queue: set proto_err; no record; txn_count unchanged.
- Start queue full on a start event: event dropped, overflow set, next_id still increments. Exception: a done event pops in the same cycle, in which case both occur.
- Record FIFO full on a done event: record dropped, overflow set, txn_count still increments. A same-cycle rec_valid & rec_ready pop frees a slot, so the push succeeds.
- finish: start events are ignored from the cycle finish=1. Done events are still processed.
- drained = finish & start queue empty & FIFO empty.

## Timing
- Reset values: rec_valid 0, all rec_* 0, txn_count 0, overflow 0, proto_err 0, drained 0; FSM in ARMED; next_id 0; `now` 0.
- Start event at cycle T records rec_start = T, where T is the value of `now` in that cycle.
- Done event at cycle D: rec_latency = D - T. rec_valid rises at D+1 if the FIFO was empty.
- FIFO is first-word-fall-through: rec_* are stable while rec_valid & !rec_ready. One record pops per cycle while rec_ready stays high.
- Sticky flags assert the cycle after the offending event and clear only on reset.
- Reset asserted mid-transaction: all queues flush immediately and the outputs take their reset values. No partial record is emitted after reset deasserts.

## Configuration
- AP_TXN_TRACKER_STALL_CNT_EN defined:
  - Adds output rec_stall [CNT_W-1:0]: the number of cycles with ap_done=1 & ap_continue=0 preceding the done event.
  - The count is carried in the record and reset to 0 on each done event.
- Macro undefined: no rec_stall port or logic.

## Structure
- Package ap_txn_pkg holds:
  - the record struct ap_txn_rec_t: id, start, latency, interval, and stall under the macro;
  - the start-queue entry struct;
  - the FSM state enum.
- Sub-module ap_txn_rec_fifo: generic first-word-fall-through synchronous FIFO, parameterized on type and depth, using the same clock and reset.
  - Instantiated twice: start queue (depth OUTST) and record FIFO (DEPTH).

## Test plan
- Single txn: start at cycle 5 with ready at 5, done&continue at 12 -> record id 0, start 5, latency 7, interval 0; txn_count 1.
- Back-to-back pipelined: starts at 10/13/16 each with ready, dones at 20/23/26 -> latencies 10,10,10; intervals 0,3,3.
- Backpressure: rec_ready=0 through 9 completed txns with DEPTH=8 -> 8 records held, overflow=1, txn_count 9. Then rec_ready=1 -> ids 0..7 drain in order.
- Stray done with no start at cycle 4 -> proto_err=1 from cycle 5, rec_valid stays 0.
- Mid-run reset: ap_rst_n low with 2 outstanding and 1 record pending -> all outputs 0 immediately; the next start after release gets id 0.
- finish asserted at cycle 30 with 1 outstanding, ap_start held -> no new start; done at 35 emits record; drained=1 once the record is popped.
